// File: rtl/disp_scroll_ctrl.sv
// Scrolling message controller for an 8-digit seven-segment display: a 16-entry
// buffer shown through a sliding 8-entry window. Optional wrap pause: SCROLL_PAUSE_EN.
module disp_scroll_ctrl #(
  parameter int unsigned STEP_CYCLES = 25000000,
  parameter int unsigned PAUSE_STEPS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic        stop,
  output logic [63:0] o_data,
  output logic        o_mode,
  output logic        busy,
  output logic        wrap
);

  localparam logic [25:0] TICK_LAST = 26'(STEP_CYCLES - 1);
`ifdef SCROLL_PAUSE_EN
  localparam logic [3:0]  PAUSE_LAST = 4'(PAUSE_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
  } state_t;
`endif

  state_t       state_q;
  logic [3:0]   base_q;
  logic [25:0]  tick_q;
  logic         busy_q;
  logic         wrap_q;
  logic         mode_q;
  logic [7:0]   buf_q [16];
  logic [63:0]  data_q;
  logic [63:0]  data_d;
`ifdef SCROLL_PAUSE_EN
  logic [3:0]   pause_q;
`endif

  // Message buffer: writable in every state, blanked (all segments off) on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= 8'hFF;
      end
    end else begin
      if (wr_en) begin
        buf_q[wr_addr] <= wr_data;
      end
    end
  end

  // Window selection: the most significant digit shows buf[base].
  always_comb begin
    data_d = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      data_d[8*k +: 8] = buf_q[4'(base_q + 4'(7 - k))];
    end
  end

  // Output register, one edge behind buffer/base changes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      data_q <= data_d;
    end
  end

  // Scroll FSM with step timer, base pointer and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      base_q  <= 4'd0;
      tick_q  <= 26'd0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      mode_q  <= 1'b1;
`ifdef SCROLL_PAUSE_EN
      pause_q <= 4'd0;
`endif
    end else begin
      wrap_q <= 1'b0;
      mode_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_q <= S_RUN;
            tick_q  <= 26'd0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
            tick_q  <= 26'd0;
            busy_q  <= 1'b0;
          end else if (tick_q == TICK_LAST) begin
            tick_q <= 26'd0;
            if (base_q == 4'd15) begin
              base_q <= 4'd0;
              wrap_q <= 1'b1;
`ifdef SCROLL_PAUSE_EN
              state_q <= S_HOLD;
              pause_q <= 4'd0;
`endif
            end else begin
              base_q <= base_q + 4'd1;
            end
          end else begin
            tick_q <= tick_q + 26'd1;
          end
        end
`ifdef SCROLL_PAUSE_EN
        // Base 0 dwells PAUSE_STEPS periods; leaving HOLD is the next step.
        S_HOLD: begin
          if (stop) begin
            state_q <= S_IDLE;
            tick_q  <= 26'd0;
            pause_q <= 4'd0;
            busy_q  <= 1'b0;
          end else if (tick_q == TICK_LAST) begin
            tick_q <= 26'd0;
            if (pause_q == PAUSE_LAST) begin
              state_q <= S_RUN;
              pause_q <= 4'd0;
              base_q  <= base_q + 4'd1;
            end else begin
              pause_q <= pause_q + 4'd1;
            end
          end else begin
            tick_q <= tick_q + 26'd1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          tick_q  <= 26'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data = data_q;
  assign o_mode = mode_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Randomized bench for disp_scroll_ctrl against a time-based reference model.
module tb_disp_scroll_ctrl;

  localparam int STEP  = 4;
  localparam int PAUSE = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic        stop;
  logic [63:0] o_data;
  logic        o_mode;
  logic        busy;
  logic        wrap;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  disp_scroll_ctrl #(.STEP_CYCLES(STEP), .PAUSE_STEPS(PAUSE)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .o_data(o_data), .o_mode(o_mode), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: running flag (0 idle, 1 scrolling, 2 pausing), elapsed cycles in step.
  int          m_mode;
  int          m_base;
  int          m_elapsed;
  int          m_pauses;
  logic [7:0]  m_buf [16];
  logic [63:0] m_od;
  logic        m_wrap;

  function automatic logic [63:0] window(int b);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[63 - 8*j -: 8] = m_buf[(b + j) % 16];
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_base = 0; m_elapsed = 0; m_pauses = 0; m_wrap = 1'b0;
      for (int i = 0; i < 16; i++) m_buf[i] = 8'hFF;
      m_od = 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      m_od   = window(m_base);
      m_wrap = 1'b0;
      if (wr_en) m_buf[wr_addr] = wr_data;
      if (m_mode == 0) begin
        if (start && !stop) begin m_mode = 1; m_elapsed = 0; end
      end else if (stop) begin
        m_mode = 0; m_elapsed = 0; m_pauses = 0;
      end else begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == STEP) begin
          m_elapsed = 0;
          if (m_mode == 2) begin
            m_pauses = m_pauses + 1;
            if (m_pauses == PAUSE) begin m_mode = 1; m_pauses = 0; m_base = 1; end
          end else begin
            m_base = (m_base + 1) % 16;
            if (m_base == 0) begin
              m_wrap = 1'b1;
`ifdef SCROLL_PAUSE_EN
              m_mode = 2; m_pauses = 0;
`endif
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_data", o_data, m_od);
      chk("busy", {63'd0, busy}, {63'd0, (m_mode != 0)});
      chk("wrap", {63'd0, wrap}, {63'd0, m_wrap});
      chk("o_mode", {63'd0, o_mode}, 64'd1);
    end
  end

  int wraps;
  bit found;

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_o_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wrap", {63'd0, wrap}, 64'd0);
    chk("rst_mode", {63'd0, o_mode}, 64'd1);

    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("fill_o_data", o_data, 64'h0001_0203_0405_0607);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("step1_o_data", o_data, 64'h0102_0304_0506_0708);
    wraps = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (wrap) wraps++;
    end
    chk("wrap_count", 64'(wraps), 64'd1);

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom % 4) == 0;
      wr_addr = 4'($urandom);
      wr_data = 8'($urandom);
      start   = ($urandom % 40) == 0;
      stop    = ($urandom % 97) == 0;
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (m_mode == 1 && m_base == 5) found = 1'b1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL base5_timeout got=0 expected=1");
    end
    #2 rstn = 1'b0;
    #1;
    chk("async_o_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_mode", {63'd0, o_mode}, 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_o_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
